// File: rtl/data_mem_resp.sv
// data_mem_resp
//   Slave end of the data_memory_* load/store interface. Accepts one word
//   access at a time, inserts WAIT_CYCLES wait states, performs the access
//   on a word-addressed internal array and returns a one-cycle completion
//   pulse with read data and an error flag.
//
// Ports
//   clk                : clock, rising edge
//   rst_n              : asynchronous active-low reset
//   data_memory_read   : read request
//   data_memory_write  : write request
//   data_memory_a      : byte address
//   data_memory_out_v  : write data from the core
//   data_memory_in_v   : read data to the core (holds last successful read)
//   data_memory_ready  : high only in IDLE
//   data_memory_valid  : one-cycle completion pulse
//   data_memory_err    : error status, meaningful while valid is high
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | ready; a read or write request is accepted at the next edge
// S_WAIT | request latched, wait counter running down to zero
// S_RESP | access done, valid/err presented for exactly one cycle
module data_mem_resp #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_memory_read,
  input  logic        data_memory_write,
  input  logic [31:0] data_memory_a,
  input  logic [31:0] data_memory_out_v,
  output logic [31:0] data_memory_in_v,
  output logic        data_memory_ready,
  output logic        data_memory_valid,
  output logic        data_memory_err
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_req_a;
  logic [31:0] r_req_wd;
  logic        r_req_rd;
  logic        r_req_wr;
  logic [31:0] r_rdata;
  logic        r_ready;
  logic        r_valid;
  logic        r_err;

  logic [31:0] r_mem [DEPTH];

  logic                  w_accept;
  logic [31:0]           w_x_a;
  logic [31:0]           w_x_wd;
  logic                  w_x_rd;
  logic                  w_x_wr;
  logic                  w_enter_resp;
  logic                  w_err;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_mem_we;
  logic                  w_mem_re;

  assign w_accept = (r_state == S_IDLE) && (data_memory_read || data_memory_write);

  // With zero wait states the access executes on the acceptance edge itself,
  // so the request being executed comes straight from the inputs in IDLE.
  assign w_x_a  = (r_state == S_IDLE) ? data_memory_a     : r_req_a;
  assign w_x_wd = (r_state == S_IDLE) ? data_memory_out_v : r_req_wd;
  assign w_x_rd = (r_state == S_IDLE) ? data_memory_read  : r_req_rd;
  assign w_x_wr = (r_state == S_IDLE) ? data_memory_write : r_req_wr;

  assign w_enter_resp = (w_accept && (WAIT_CYCLES == 0)) ||
                        ((r_state == S_WAIT) && (r_cnt == 4'd0));

  assign w_err = (w_x_a[1:0] != 2'b00) ||
                 ((w_x_a >> (DEPTH_LOG2 + 2)) != 32'd0) ||
                 (w_x_rd && w_x_wr);

  assign w_idx = w_x_a[DEPTH_LOG2+1:2];

  // rst_n gating keeps a zero-wait request seen during reset from writing.
  assign w_mem_we = rst_n && w_enter_resp && !w_err && w_x_wr;
  assign w_mem_re = w_enter_resp && !w_err && w_x_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_req_a  <= 32'd0;
      r_req_wd <= 32'd0;
      r_req_rd <= 1'b0;
      r_req_wr <= 1'b0;
      r_rdata  <= 32'd0;
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_req_a  <= data_memory_a;
            r_req_wd <= data_memory_out_v;
            r_req_rd <= data_memory_read;
            r_req_wr <= data_memory_write;
            r_ready  <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              r_state <= S_RESP;
              r_valid <= 1'b1;
              r_err   <= w_err;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= WAIT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
            r_valid <= 1'b1;
            r_err   <= w_err;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_valid <= 1'b0;
          r_err   <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_valid <= 1'b0;
          r_err   <= 1'b0;
        end
      endcase

      if (w_mem_re) begin
        r_rdata <= r_mem[w_idx];
      end
    end
  end

  // Storage is deliberately not reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_idx] <= w_x_wd;
    end
  end

  assign data_memory_in_v  = r_rdata;
  assign data_memory_ready = r_ready;
  assign data_memory_valid = r_valid;
  assign data_memory_err   = r_err;

endmodule

// File: tb/tb_data_mem_resp.sv
module tb_data_mem_resp;

  logic        clk;
  logic        rst_n [3];
  logic        rd    [3];
  logic        wr    [3];
  logic [31:0] a     [3];
  logic [31:0] wd    [3];
  logic [31:0] rdata [3];
  logic        ready [3];
  logic        valid [3];
  logic        err   [3];

  int checks = 0;
  int errors = 0;

  // Instance 0: WAIT_CYCLES=1, instance 1: 0, instance 2: 3.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_resp #(
      .DEPTH_LOG2 (10),
      .WAIT_CYCLES((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .clk              (clk),
      .rst_n            (rst_n[g]),
      .data_memory_read (rd[g]),
      .data_memory_write(wr[g]),
      .data_memory_a    (a[g]),
      .data_memory_out_v(wd[g]),
      .data_memory_in_v (rdata[g]),
      .data_memory_ready(ready[g]),
      .data_memory_valid(valid[g]),
      .data_memory_err  (err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One access; returns err/data sampled with valid and the number of
  // falling edges from acceptance to the valid cycle (0 = timeout).
  task automatic do_access(input int k, input logic r, input logic w,
                           input logic [31:0] ad, input logic [31:0] dv,
                           output logic e, output logic [31:0] d, output int lat);
    int n;
    e = 1'b0; d = 32'd0; lat = 0; n = 0;
    @(negedge clk);
    while (!ready[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    rd[k] = r; wr[k] = w; a[k] = ad; wd[k] = dv;
    @(posedge clk);
    #1;
    rd[k] = 1'b0; wr[k] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) chk("ready_low_after_accept", 32'(ready[k]), 32'd0);
      if (valid[k]) begin
        lat = i;
        e = err[k];
        d = rdata[k];
        break;
      end
    end
    if (lat == 0) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  // Reference model for instance 0: word store keyed by word index plus the
  // last successfully read value.
  logic [31:0] mdl_mem [int];
  logic [31:0] mdl_last = 32'd0;

  task automatic model_step(input logic r, input logic w, input logic [31:0] ad,
                            input logic [31:0] dv, output logic e, output logic [31:0] d);
    e = (ad % 4 != 0) || (ad >= 32'd4096) || (r && w);
    if (!e) begin
      if (w) mdl_mem[int'(ad / 4)] = dv;
      else if (r) mdl_last = mdl_mem[int'(ad / 4)];
    end
    d = mdl_last;
  endtask

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] ad;
    logic [31:0] dv;
    logic        exp_e;
    logic [31:0] exp_d;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic        e, me;
    logic [31:0] d, md;
    int          lat;
    bit          known [16];

    vecs[0]  = '{1'b0, 1'b1, 32'h10,       32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 1'b0, 32'h12,       32'h0,        1'b1, 32'hDEADBEEF};
    vecs[3]  = '{1'b0, 1'b1, 32'h0,        32'h0BADF00D, 1'b0, 32'hDEADBEEF};
    vecs[4]  = '{1'b0, 1'b1, 32'h1000,     32'h1234,     1'b1, 32'hDEADBEEF};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0BADF00D};
    vecs[6]  = '{1'b0, 1'b1, 32'h20,       32'h11112222, 1'b0, 32'h0BADF00D};
    vecs[7]  = '{1'b1, 1'b1, 32'h20,       32'hAA,       1'b1, 32'h0BADF00D};
    vecs[8]  = '{1'b1, 1'b0, 32'h20,       32'h0,        1'b0, 32'h11112222};
    vecs[9]  = '{1'b0, 1'b1, 32'hFFC,      32'h77,       1'b0, 32'h11112222};
    vecs[10] = '{1'b1, 1'b0, 32'hFFC,      32'h0,        1'b0, 32'h77};
    vecs[11] = '{1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,        1'b1, 32'h77};

    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; rd[k] = 1'b0; wr[k] = 1'b0; a[k] = 32'd0; wd[k] = 32'd0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_ready", 32'(ready[k]), 32'd1);
      chk("reset_valid", 32'(valid[k]), 32'd0);
      chk("reset_err",   32'(err[k]),   32'd0);
      chk("reset_rdata", rdata[k],      32'd0);
      rst_n[k] = 1'b1;
    end

    // Directed table on WAIT_CYCLES=1; model tracks the same traffic.
    for (int i = 0; i < 12; i++) begin
      do_access(0, vecs[i].r, vecs[i].w, vecs[i].ad, vecs[i].dv, e, d, lat);
      model_step(vecs[i].r, vecs[i].w, vecs[i].ad, vecs[i].dv, me, md);
      chk($sformatf("vec%0d_err", i),  32'(e), 32'(vecs[i].exp_e));
      chk($sformatf("vec%0d_data", i), d,      vecs[i].exp_d);
      chk($sformatf("vec%0d_lat", i),  32'(lat), 32'd2);
    end

    // Randomized traffic against the model in a region 0x100..0x13C.
    for (int i = 0; i < 16; i++) known[i] = 1'b0;
    for (int i = 0; i < 60; i++) begin
      int          sel, idx;
      logic        r, w;
      logic [31:0] ad, dv;
      sel = int'($urandom_range(0, 9));
      idx = int'($urandom_range(0, 15));
      ad  = 32'h100 + 32'(idx * 4);
      dv  = $urandom;
      r   = 1'b0; w = 1'b0;
      case (sel)
        0: begin ad = ad + 32'($urandom_range(1, 3)); r = $urandom_range(0, 1) == 1; w = !r; end
        1: begin ad = ad | 32'h0001_0000; r = 1'b1; end
        2: begin r = 1'b1; w = 1'b1; end
        3, 4, 5: w = 1'b1;
        default: begin if (known[idx]) r = 1'b1; else w = 1'b1; end
      endcase
      if (w && !r && sel >= 3) known[idx] = 1'b1;
      do_access(0, r, w, ad, dv, e, d, lat);
      model_step(r, w, ad, dv, me, md);
      chk($sformatf("rnd%0d_err", i),  32'(e), 32'(me));
      chk($sformatf("rnd%0d_data", i), d,      md);
      chk($sformatf("rnd%0d_lat", i),  32'(lat), 32'd2);
    end

    // Back-to-back reads with zero wait states and request held high.
    do_access(1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, e, d, lat);
    chk("b2b_write_err", 32'(e),   32'd0);
    chk("b2b_write_lat", 32'(lat), 32'd1);
    @(negedge clk);
    rd[1] = 1'b1; a[1] = 32'h10;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk($sformatf("b2b_valid%0d", i), 32'(valid[1]), 32'(i % 2));
      chk($sformatf("b2b_ready%0d", i), 32'(ready[1]), 32'((i + 1) % 2));
      if (valid[1]) begin
        chk($sformatf("b2b_data%0d", i), rdata[1], 32'hDEADBEEF);
        chk($sformatf("b2b_err%0d", i),  32'(err[1]), 32'd0);
      end
    end
    rd[1] = 1'b0;

    // Reset while a write sits in WAIT.
    do_access(2, 1'b0, 1'b1, 32'h30, 32'h12345678, e, d, lat);
    chk("rst_pre_write_err", 32'(e),   32'd0);
    chk("rst_pre_write_lat", 32'(lat), 32'd4);
    do_access(2, 1'b1, 1'b0, 32'h30, 32'h0, e, d, lat);
    chk("rst_pre_read_data", d, 32'h12345678);
    @(negedge clk);
    wr[2] = 1'b1; a[2] = 32'h30; wd[2] = 32'h55;
    @(posedge clk);
    #1;
    wr[2] = 1'b0;
    @(negedge clk);
    chk("rst_in_wait_ready", 32'(ready[2]), 32'd0);
    rst_n[2] = 1'b0;
    #1;
    chk("rst_async_ready", 32'(ready[2]), 32'd1);
    chk("rst_async_valid", 32'(valid[2]), 32'd0);
    chk("rst_async_err",   32'(err[2]),   32'd0);
    chk("rst_async_rdata", rdata[2],      32'd0);
    repeat (2) @(negedge clk);
    rst_n[2] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("rst_no_valid%0d", i), 32'(valid[2]), 32'd0);
    end
    do_access(2, 1'b1, 1'b0, 32'h30, 32'h0, e, d, lat);
    chk("rst_post_read_err",  32'(e), 32'd0);
    chk("rst_post_read_data", d,      32'h12345678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
